// File: rtl/gpu_pixel_write_buffer_pkg.sv
// gpu_pixel_write_buffer_pkg: shared line-buffer constants, FSM encoding and line-key helper
package gpu_pixel_write_buffer_pkg;
  localparam int PIX_PER_LINE = 8;
  localparam int LINE_KEY_W = 16;
  localparam int PIX_W = 16;
  localparam int LINE_W = PIX_PER_LINE * PIX_W;
  localparam int IDX_W = $clog2(PIX_PER_LINE);
  typedef enum logic [2:0] {S_EMPTY, S_FILL, S_PEND, S_FULL, S_STALL} wb_state_t;
  function automatic logic [LINE_KEY_W-1:0] line_key(input logic [9:0] x, input logic [8:0] y);
    return {y, x[9:3]};
  endfunction
endpackage

// File: rtl/gpu_line_slot.sv
// gpu_line_slot: one 8-pixel line buffer with key, per-slot mask and valid bit
module gpu_line_slot
  import gpu_pixel_write_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_copy,
  input  logic                  i_load,
  input  logic                  i_wr,
  input  logic                  i_clr,
  input  logic [LINE_KEY_W-1:0] i_key,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [PIX_W-1:0]      i_pix,
  input  logic [LINE_W-1:0]     i_cdata,
  input  logic [PIX_PER_LINE-1:0] i_cmask,
  output logic                  o_valid,
  output logic [LINE_KEY_W-1:0] o_key,
  output logic [PIX_PER_LINE-1:0] o_mask,
  output logic [LINE_W-1:0]     o_data
);
  logic                    r_valid;
  logic [LINE_KEY_W-1:0]   r_key;
  logic [PIX_PER_LINE-1:0] r_mask;
  logic [LINE_W-1:0]       r_data;
  logic [PIX_PER_LINE-1:0] w_bit;
  assign w_bit = {{(PIX_PER_LINE-1){1'b0}}, 1'b1} << i_idx;
  // Copy wins over pixel writes; load starts a fresh line keeping stale unmasked data
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_key   <= '0;
      r_mask  <= '0;
      r_data  <= '0;
    end else if (i_copy) begin
      r_valid <= 1'b1;
      r_key   <= i_key;
      r_mask  <= i_cmask;
      r_data  <= i_cdata;
    end else if (i_load || i_wr) begin
      r_valid <= 1'b1;
      r_key   <= i_load ? i_key : r_key;
      r_mask  <= (i_load ? '0 : r_mask) | w_bit;
      r_data[PIX_W*i_idx +: PIX_W] <= i_pix;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end
  end
  assign o_valid = r_valid;
  assign o_key   = r_key;
  assign o_mask  = r_mask;
  assign o_data  = r_data;
endmodule

// File: rtl/gpu_pixel_write_buffer.sv
// gpu_pixel_write_buffer: double-buffered 8-pixel line coalescer between pixel pipe and VRAM arbiter
module gpu_pixel_write_buffer
  import gpu_pixel_write_buffer_pkg::*;
#(
  parameter bit FLUSH_ON_SPIKE = 1'b1
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_valid,
  input  logic [1:0]   i_stateSpike,
  input  logic [9:0]   i_scrX,
  input  logic [8:0]   i_scrY,
  input  logic [15:0]  i_color,
  input  logic         i_flush,
  output logic         o_pause,
  output logic         o_flushReq,
  output logic [15:0]  o_flushAdr,
  output logic [127:0] o_flushData,
  output logic [7:0]   o_flushMask,
  input  logic         i_flushAck,
  output logic         o_busy
);
  wb_state_t               r_state;
  logic                    r_flush_hold;
  logic                    w_a_valid, w_p_valid;
  logic [LINE_KEY_W-1:0]   w_a_key, w_key;
  logic [PIX_PER_LINE-1:0] w_a_mask;
  logic [LINE_W-1:0]       w_a_data;
  logic                    w_close_req, w_close, w_consume, w_a_nxt, w_p_nxt;
  assign w_key = line_key(i_scrX, i_scrY);
  assign w_close_req = w_a_valid & ((i_valid & (w_key != w_a_key))
                     | (i_valid & FLUSH_ON_SPIKE & |i_stateSpike)
                     | i_flush | r_flush_hold);
  // Ack frees PENDING in the same cycle, so a close can refill it on that edge
  assign o_pause   = ~i_rst & w_close_req & w_p_valid & ~i_flushAck;
  assign w_close   = ~i_rst & w_close_req & ~o_pause;
  assign w_consume = ~i_rst & i_valid & ~o_pause;
  assign w_a_nxt   = w_close ? w_consume : (w_a_valid | w_consume);
  assign w_p_nxt   = w_close | (w_p_valid & ~i_flushAck);
  gpu_line_slot u_active (
    .clk(clk), .i_rst(i_rst),
    .i_copy(1'b0),
    .i_load(w_consume & (w_close | ~w_a_valid)),
    .i_wr(w_consume & ~w_close & w_a_valid),
    .i_clr(w_close),
    .i_key(w_key), .i_idx(i_scrX[2:0]), .i_pix(i_color),
    .i_cdata('0), .i_cmask('0),
    .o_valid(w_a_valid), .o_key(w_a_key), .o_mask(w_a_mask), .o_data(w_a_data)
  );
  gpu_line_slot u_pending (
    .clk(clk), .i_rst(i_rst),
    .i_copy(w_close), .i_load(1'b0), .i_wr(1'b0),
    .i_clr(i_flushAck),
    .i_key(w_a_key), .i_idx(i_scrX[2:0]), .i_pix(i_color),
    .i_cdata(w_a_data), .i_cmask(w_a_mask),
    .o_valid(w_p_valid), .o_key(o_flushAdr), .o_mask(o_flushMask), .o_data(o_flushData)
  );
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state      <= S_EMPTY;
      r_flush_hold <= 1'b0;
    end else begin
      r_state      <= (w_a_nxt & w_p_nxt) ? (o_pause ? S_STALL : S_FULL)
                    : w_a_nxt ? S_FILL : w_p_nxt ? S_PEND : S_EMPTY;
      r_flush_hold <= w_close ? 1'b0 : (r_flush_hold | (i_flush & w_a_valid));
    end
  end
  assign o_flushReq = w_p_valid;
  assign o_busy     = r_state != S_EMPTY;
endmodule

// File: tb/tb_gpu_pixel_write_buffer.sv
// tb_gpu_pixel_write_buffer: table-driven directed vectors plus a stalled-flush sequence
module tb_gpu_pixel_write_buffer;
  logic         clk = 1'b0;
  logic         i_rst, i_valid, i_flush, i_flushAck;
  logic [1:0]   i_stateSpike;
  logic [9:0]   i_scrX;
  logic [8:0]   i_scrY;
  logic [15:0]  i_color;
  logic         o_pause, o_flushReq, o_busy;
  logic [15:0]  o_flushAdr;
  logic [127:0] o_flushData;
  logic [7:0]   o_flushMask;
  int n_vec = 0, n_err = 0;

  gpu_pixel_write_buffer dut (
    .clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_stateSpike(i_stateSpike),
    .i_scrX(i_scrX), .i_scrY(i_scrY), .i_color(i_color), .i_flush(i_flush),
    .o_pause(o_pause), .o_flushReq(o_flushReq), .o_flushAdr(o_flushAdr),
    .o_flushData(o_flushData), .o_flushMask(o_flushMask), .i_flushAck(i_flushAck),
    .o_busy(o_busy)
  );
  always #5 clk = ~clk;

  typedef struct {
    logic rst, v; logic [1:0] sp; logic [9:0] x; logic [8:0] y; logic [15:0] c;
    logic fl, ak, chk, pause, freq, busy, full;
    logic [15:0] adr; logic [7:0] mask; logic [127:0] dat;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(input logic rst, v, input logic [1:0] sp, input logic [9:0] x,
      input logic [8:0] y, input logic [15:0] c, input logic fl, ak, chk, pause, freq, busy, full,
      input logic [15:0] adr, input logic [7:0] mask, input logic [127:0] dat);
    vec_t t;
    t = '{rst, v, sp, x, y, c, fl, ak, chk, pause, freq, busy, full, adr, mask, dat};
    return t;
  endfunction

  function automatic logic [127:0] expand(input logic [7:0] m);
    logic [127:0] r;
    for (int k = 0; k < 8; k++) r[16*k +: 16] = {16{m[k]}};
    return r;
  endfunction

  task automatic check(input string nm, input logic [127:0] got, exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic rst, v, input logic [1:0] sp, input logic [9:0] x,
      input logic [8:0] y, input logic [15:0] c, input logic fl, ak);
    i_rst = rst; i_valid = v; i_stateSpike = sp; i_scrX = x; i_scrY = y;
    i_color = c; i_flush = fl; i_flushAck = ak;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] d36, dm;
    vec_t t;
    d36 = '0;
    for (int k = 0; k < 8; k++) d36[16*k +: 16] = 16'hA000 + 16'(k);
    tv.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0, 1,0,0,0,1, 0,0,0));
    for (int k = 0; k < 8; k++)
      tv.push_back(mk(0,1,0,10'(k),5,16'hA000+16'(k),0,0, 1,0,0,k>0,0, 0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,1,0, 1,0,0,1,0, 0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0, 1,0,1,1,1, 16'h0280,8'hFF,d36));
    tv.push_back(mk(0,0,0,0,0,0,0,1, 1,0,1,1,1, 16'h0280,8'hFF,d36));
    tv.push_back(mk(0,0,0,0,0,0,0,0, 1,0,0,0,0, 0,0,0));
    tv.push_back(mk(0,1,0,3,0,16'h1234,0,0, 1,0,0,0,0, 0,0,0));
    tv.push_back(mk(0,1,0,11,0,16'h5678,0,0, 1,0,0,1,0, 0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0, 1,0,1,1,1, 16'h0000,8'h08,128'h1234<<48));
    for (int k = 0; k < 2; k++)
      tv.push_back(mk(0,1,0,16,0,16'h9ABC,0,0, 1,1,1,1,1, 16'h0000,8'h08,128'h1234<<48));
    tv.push_back(mk(0,1,0,16,0,16'h9ABC,0,1, 1,0,1,1,1, 16'h0000,8'h08,128'h1234<<48));
    tv.push_back(mk(0,0,0,0,0,0,0,0, 1,0,1,1,1, 16'h0001,8'h08,128'h5678<<48));
    tv.push_back(mk(0,0,0,0,0,0,0,1, 1,0,1,1,1, 16'h0001,8'h08,128'h5678<<48));
    tv.push_back(mk(0,0,0,0,0,0,1,0, 1,0,0,1,0, 0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0, 1,0,1,1,1, 16'h0002,8'h01,128'h9ABC));
    tv.push_back(mk(0,0,0,0,0,0,0,1, 1,0,1,1,1, 16'h0002,8'h01,128'h9ABC));
    tv.push_back(mk(0,0,0,0,0,0,0,0, 1,0,0,0,0, 0,0,0));
    tv.push_back(mk(0,1,0,2,1,16'h1111,0,0, 1,0,0,0,0, 0,0,0));
    tv.push_back(mk(0,1,0,2,1,16'h2222,0,0, 1,0,0,1,0, 0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,1,0, 1,0,0,1,0, 0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0, 1,0,1,1,1, 16'h0080,8'h04,128'h2222<<32));
    tv.push_back(mk(0,0,0,0,0,0,0,1, 1,0,1,1,1, 16'h0080,8'h04,128'h2222<<32));
    tv.push_back(mk(0,1,0,8,3,16'h3333,0,0, 1,0,0,0,0, 0,0,0));
    tv.push_back(mk(0,1,0,9,3,16'h4444,0,0, 1,0,0,1,0, 0,0,0));
    tv.push_back(mk(0,1,1,10,3,16'h5555,0,0, 1,0,0,1,0, 0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0, 1,0,1,1,1, 16'h0181,8'h03,128'h4444_3333));
    tv.push_back(mk(0,0,0,0,0,0,0,1, 1,0,1,1,1, 16'h0181,8'h03,128'h4444_3333));
    tv.push_back(mk(0,0,0,0,0,0,1,0, 1,0,0,1,0, 0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0, 1,0,1,1,1, 16'h0181,8'h04,128'h5555<<32));
    tv.push_back(mk(0,0,0,0,0,0,0,1, 1,0,1,1,1, 16'h0181,8'h04,128'h5555<<32));
    tv.push_back(mk(0,1,0,0,7,16'h7000,0,0, 1,0,0,0,0, 0,0,0));
    tv.push_back(mk(0,1,0,8,7,16'h7001,0,0, 1,0,0,1,0, 0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,1, 1,0,1,1,1, 16'h0380,8'h01,128'h7000));
    tv.push_back(mk(0,0,0,0,0,0,0,0, 1,0,0,0,1, 0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,1,0, 1,0,0,0,1, 0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0, 1,0,0,0,1, 0,0,0));
    drive(0,0,0,0,0,0,0,0);
    step();
    foreach (tv[i]) begin
      t = tv[i];
      drive(t.rst, t.v, t.sp, t.x, t.y, t.c, t.fl, t.ak);
      #1;
      if (t.chk) begin
        check($sformatf("v%0d pause", i), 128'(o_pause), 128'(t.pause));
        check($sformatf("v%0d flushReq", i), 128'(o_flushReq), 128'(t.freq));
        check($sformatf("v%0d busy", i), 128'(o_busy), 128'(t.busy));
        if (t.full) begin
          dm = t.freq ? expand(t.mask) : '1;
          check($sformatf("v%0d adr", i), 128'(o_flushAdr), 128'(t.adr));
          check($sformatf("v%0d mask", i), 128'(o_flushMask), 128'(t.mask));
          check($sformatf("v%0d data", i), o_flushData & dm, t.dat);
        end
      end
      step();
    end
    // Flush arriving while PENDING is occupied must be held and stall the pipe until ack
    drive(0,1,0,0,2,16'hBEEF,0,0); step();
    drive(0,1,0,8,2,16'hCAFE,0,0); step();
    drive(0,0,0,0,0,0,1,0); #1;
    check("hold pause@flush", 128'(o_pause), 128'(1));
    check("hold adr", 128'(o_flushAdr), 128'(16'h0100));
    step();
    drive(0,0,0,0,0,0,0,0); #1;
    check("hold pause@held", 128'(o_pause), 128'(1));
    check("hold req", 128'(o_flushReq), 128'(1));
    step();
    drive(0,0,0,0,0,0,0,1); #1;
    check("hold pause@ack", 128'(o_pause), 128'(0));
    step();
    drive(0,0,0,0,0,0,0,0); #1;
    check("hold new adr", 128'(o_flushAdr), 128'(16'h0101));
    check("hold new mask", 128'(o_flushMask), 128'(8'h01));
    check("hold new data", o_flushData & expand(8'h01), 128'hCAFE);
    check("hold pause idle", 128'(o_pause), 128'(0));
    drive(0,0,0,0,0,0,0,1); step();
    drive(0,0,0,0,0,0,0,0); #1;
    check("hold busy end", 128'(o_busy), 128'(0));
    check("hold req end", 128'(o_flushReq), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/gpu_pixel_write_buffer.md
GPU_PIXEL_WRITE_BUFFER -- requirements
Module: gpu_pixel_write_buffer

Interface
REQ-001 SHALL have parameter FLUSH_ON_SPIKE, default 1: 1 = close the active line when a new primitive starts (i_stateSpike != 0).
REQ-002 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-003 SHALL have port i_rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_valid  in  1  pixel from pipe stage 2 is valid.
REQ-005 SHALL have port i_stateSpike  in  2  primitive-start marker qualified by i_valid.
REQ-006 SHALL have port i_scrX  in  10  screen X.
REQ-007 SHALL have port i_scrY  in  9  screen Y.
REQ-008 SHALL have port i_color  in  16  final pixel, with bit15 as the mask bit.
REQ-009 SHALL have port i_flush  in  1  single-cycle request to close the active line (end of primitive or CPU sync).
REQ-010 SHALL have port o_pause  out  1  stall to the pixel pipe; the presented pixel is not consumed.
REQ-011 SHALL have port o_flushReq  out  1  pending line is ready for VRAM write.
REQ-012 SHALL have port o_flushAdr  out  16  line address {Y[8:0], X[9:3]}.
REQ-013 SHALL have port o_flushData  out  128  eight pixels, with slot k at bits [16k+15:16k].
REQ-014 SHALL have port o_flushMask  out  8  per-slot written flag.
REQ-015 SHALL have port i_flushAck  in  1  single-cycle pulse: pending line taken by the memory arbiter.
REQ-016 SHALL have port o_busy  out  1  active or pending buffer holds data.

Function
REQ-017 SHALL hold two 8-pixel line buffers: ACTIVE (filling) and PENDING (awaiting write), each with a valid bit, a 16-bit key and an 8-bit mask.
REQ-018 SHALL treat a pixel as consumed in any cycle with i_valid=1 and o_pause=0.
REQ-019 SHALL, for a consumed pixel matching the ACTIVE key with ACTIVE valid, write i_color to slot i_scrX[2:0], set that mask bit, and let a later write to the same slot overwrite the earlier one.
REQ-020 SHALL, for a consumed pixel when ACTIVE is invalid, load the key, clear the mask and write the pixel, making ACTIVE valid.
REQ-021 SHALL define "close" as: ACTIVE moves to PENDING (data, key, mask), ACTIVE becomes invalid, and PENDING becomes valid.
REQ-022 SHALL require a close when ACTIVE is valid and any of the following holds: a valid pixel whose key differs; a valid pixel with i_stateSpike != 0 and FLUSH_ON_SPIKE=1; or i_flush=1.
REQ-023 SHALL perform a required close at the clock edge when PENDING is free or i_flushAck=1 in the same cycle; a pixel that triggered the close is then written into the new ACTIVE on that same edge.
REQ-024 SHALL, when a close is required but PENDING is occupied and i_flushAck=0, assert o_pause combinationally, leave ACTIVE unchanged, and hold i_flush pending internally until the close completes.
REQ-025 SHALL use o_pause = close_required & PENDING_valid & !i_flushAck, and assert it only for valid-pixel or flush-triggered closes.
REQ-026 SHALL drive o_flushReq = PENDING_valid, and hold o_flushAdr, o_flushData and o_flushMask stable while o_flushReq=1.
REQ-027 SHALL clear PENDING_valid on the edge after i_flushAck=1 unless a close refills it on that same edge; i_flushAck with PENDING invalid SHALL be ignored.
REQ-028 SHALL assert o_flushReq one cycle after the consume or flush edge that performs the close.
REQ-029 SHALL implement the FSM states EMPTY (neither buffer valid), FILL (ACTIVE only), PEND (PENDING only), FULL (both) and STALL (FULL with a close outstanding); STALL SHALL go to FILL or FULL on i_flushAck.
REQ-030 SHALL treat i_flush with ACTIVE invalid as a no-op.
REQ-031 SHALL drive o_busy = ACTIVE_valid | PENDING_valid.

Reset
REQ-032 SHALL, when i_rst=1, clear both valid bits, both masks and any held flush, force the FSM to EMPTY, and drive o_pause=0, o_flushReq=0, o_busy=0, with data/key/address set to 0.
REQ-033 SHALL let reset mid-operation discard buffered pixels without issuing a write; i_flushAck during reset is ignored.

Structure
REQ-034 SHALL take the FSM state encoding and the constants PIX_PER_LINE=8 and LINE_KEY_W=16 from the shared GPU package.
REQ-035 SHALL have a single sub-module gpu_line_slot, instantiated twice, holding data, mask, key and valid for one line buffer.

Verification
REQ-036 Bench SHALL apply 8 pixels at X=0..7, Y=5, then i_flush -> flushReq with adr=0x0280 and mask=0xFF, and data slots in order.
REQ-037 Bench SHALL apply X=3 then X=11, Y=0, with no ack -> first line pending (adr=0x0000, mask=0x08), ACTIVE key=0x0001, and no pause.
REQ-038 Bench SHALL, with PENDING held (no ack), apply pixels on a third line -> o_pause=1 each cycle; pulsing ack -> pause drops the same cycle and the pixel is consumed on that edge.
REQ-039 Bench SHALL apply X=2 twice with colors 0x1111 then 0x2222 -> slot2=0x2222 and mask=0x04.
REQ-040 Bench SHALL assert i_rst while FULL -> the next cycle shows flushReq=0, busy=0, pause=0, and no write occurs.
REQ-041 Bench SHALL apply i_stateSpike=01 on a same-key pixel with FLUSH_ON_SPIKE=1 -> close happens, the new ACTIVE holds only that pixel, and mask=one bit.
